// File: rtl/cla_multiword_sequencer_if.sv
// Operand/result bundle for cla_multiword_sequencer.
//   in_valid/in_ready   : operand handshake (producer -> sequencer)
//   in_a, in_b          : W*NW-bit operands
//   in_sub, in_cin      : 1 = A-B, 0 = A+B; carry-in for add only
//   out_valid/out_ready : result handshake (sequencer -> consumer)
//   out_sum, out_cout   : W*NW-bit result, carry out of MSB (1 = no borrow on subtract)
//   out_ovf             : signed overflow
//   busy                : operation in flight or result waiting
interface cla_multiword_sequencer_if #(
  parameter int W  = 32,
  parameter int NW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [W*NW-1:0] in_a;
  logic [W*NW-1:0] in_b;
  logic            in_sub;
  logic            in_cin;
  logic            out_valid;
  logic            out_ready;
  logic [W*NW-1:0] out_sum;
  logic            out_cout;
  logic            out_ovf;
  logic            busy;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
  );
endinterface

// File: rtl/cla_multiword_sequencer.sv
// Iterative wide adder/subtractor. One W-bit CLA slice is reused over NW beats;
// the carry between beats lives in a flop.
//   cla_slice               : N-bit carry-lookahead adder built from K-bit blocks
//   cla_multiword_sequencer : CLOCK_50, reset_n (sync, active low), bus (slave modport)
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// RUN   | one slice beat per cycle, LSW first
// DONE  | result presented and held until out_ready

module cla_slice #(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int NB = (N + K - 1) / K;

  always_comb begin : cla_logic
    logic [N-1:0]  g;
    logic [N-1:0]  p;
    logic [N-1:0]  c;
    logic [NB:0]   bc;
    logic          bg;
    logic          bp;
    g  = a & b;
    p  = a ^ b;
    bc = '0;
    c  = '0;
    bc[0] = cin;
    // block-level generate/propagate, then lookahead across blocks
    for (int j = 0; j < NB; j++) begin
      bg = 1'b0;
      bp = 1'b1;
      for (int i = j * K; (i < (j + 1) * K) && (i < N); i++) begin
        bg = g[i] | (p[i] & bg);
        bp = bp & p[i];
      end
      bc[j+1] = bg | (bp & bc[j]);
    end
    // bit carries inside each block start from that block's lookahead carry
    c[0] = cin;
    for (int i = 1; i < N; i++) begin
      c[i] = ((i % K) == 0) ? bc[i/K] : (g[i-1] | (p[i-1] & c[i-1]));
    end
    sum  = p ^ c;
    cout = bc[NB];
  end
endmodule

module cla_multiword_sequencer #(
  parameter int W  = 32,
  parameter int K  = 4,
  parameter int NW = 4
) (
  input logic                     CLOCK_50,
  input logic                     reset_n,
  cla_multiword_sequencer_if.slave bus
);
  localparam int WT = W * NW;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry_q;
  logic [WT-1:0] a_q;
  logic [WT-1:0] b_q;
  logic [WT-1:0] sum_q;
  logic          cout_q;
  logic          ovf_q;

  logic [31:0]   base;
  logic [W-1:0]  sl_a;
  logic [W-1:0]  sl_b;
  logic [W-1:0]  sl_sum;
  logic          sl_cout;

  assign base = 32'(cnt) * 32'(W);
  assign sl_a = a_q[base +: W];
  assign sl_b = b_q[base +: W];

  cla_slice #(.N(W), .K(K)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            // subtract as A + ~B + 1; the +1 rides in on the carry flop
            b_q     <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_q <= bus.in_sub ? 1'b1 : bus.in_cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[base +: W] <= sl_sum;
          carry_q          <= sl_cout;
          cnt              <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_q <= sl_cout;
            ovf_q  <= (a_q[WT-1] == b_q[WT-1]) & (sl_sum[W-1] != a_q[WT-1]);
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: doc/cla_multiword_sequencer.md
Name: cla_multiword_sequencer

Overview:
- Iterative wide add/subtract unit: a single W-bit hierarchical CLA slice is time-shared over NW beats to add/subtract (W*NW)-bit operands.
- Carry chains between beats through a registered carry flop.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes, with backpressure on the output.
- Intended as the wide-integer and mantissa adder front end of the FPU datapath.

Parameters:
- W, 32, slice width in bits; passed as N to the internal CLA.
- K, 4, CLA block width; passed through to the internal CLA.
- NW, 4, number of beats (words); operand width is W*NW. Legal range NW >= 1, W >= 1.

Ports:
- CLOCK_50  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the CLOCK_50 rising edge.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept an operand.
- in_a  input  W*NW  operand A.
- in_b  input  W*NW  operand B.
- in_sub  input  1  1 = A - B (two's complement), 0 = A + B.
- in_cin  input  1  carry-in for add; ignored when in_sub = 1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  W*NW  result.
- out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
- out_ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (reset_n low at an edge):
  - state = IDLE, beat counter = 0, carry flop = 0.
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, busy = 0, in_ready = 1 in the next cycle.
  - Takes priority over every other event.
  - Reset during RUN or DONE discards the operation. No partial result is ever presented.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready at edge t0:
    - capture A.
    - capture B_eff = in_sub ? ~in_b : in_b.
    - set carry flop = in_sub ? 1 : in_cin.
    - clear beat counter; go to RUN.
  - RUN: in_ready = 0. Each edge processes beat i = counter:
    - slice inputs: A[i*W +: W], B_eff[i*W +: W], Cin = carry flop.
    - write slice sum into out_sum[i*W +: W].
    - load carry flop with slice Cout.
    - counter increments.
    - At the edge processing beat NW-1:
      - latch out_cout = slice Cout.
      - compute out_ovf = (A_msb == B_eff_msb) & (sum_msb != A_msb).
      - go to DONE.
  - DONE: out_valid = 1; out_sum, out_cout and out_ovf are held stable. On out_valid & out_ready, go to IDLE and drop out_valid next cycle.
- Latency and throughput:
  - Accept at edge t0; out_valid is high in the cycle following edge t0+NW, i.e. NW cycles after acceptance.
  - Minimum initiation interval is NW+2 cycles. There is no in/out bypass, and in_ready is 0 in the DONE cycle even when out_ready = 1.
- Handshake rules:
  - Operands are captured only at acceptance; in_a, in_b, in_sub and in_cin may change freely afterwards.
  - in_valid while busy is ignored, not queued.
  - out_valid never drops without out_ready.
  - The consumer may hold out_ready low indefinitely.
  - out_ready high while out_valid = 0 has no effect.
- out_sum during RUN holds partial/stale words and must not be sampled. Only out_valid qualifies the result.
- Widths:
  - Beat counter is clog2(NW) bits, minimum 1.
  - With NW = 1, RUN lasts exactly one cycle.
- Arithmetic: everything is modulo 2^(W*NW). Wrap-around is reported only via out_cout and out_ovf, never saturated.

Test Plan (W=32, NW=4, K=4):
- Reset then add:
  - Stimulus: A=0x0000_0000_0000_0000_0000_0001_FFFF_FFFF, B=1, sub=0, cin=0.
  - Required: out_valid 4 cycles after accept; sum=0x...0002_0000_0000; cout=0; ovf=0; carry crosses the beat boundary.
- Full-width carry ripple:
  - Stimulus: A=all ones (128 bits), B=0, cin=1.
  - Required: sum=0, cout=1, ovf=0.
- Subtract with borrow and signed overflow:
  - Stimulus: A=0x8000...0000, B=1, sub=1.
  - Required: sum=0x7FFF...FFFF, cout=1, ovf=1.
  - Stimulus: A=0, B=1, sub=1.
  - Required: sum=all ones, cout=0, ovf=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
  - Required: result stable, in_ready=0 throughout, in_valid ignored.
  - Then: release out_ready; in_ready=1 the next cycle; a back-to-back second request gives the correct, independent result.
- Reset mid-RUN:
  - Stimulus: reset_n low at beat 2 of an operation.
  - Required: next cycle state IDLE, out_valid=0, out_sum=0, in_ready=1; a following add of 5+7 returns 12.
- Random compare:
  - Stimulus: 1000 random A, B, sub, cin values with random out_ready stalls.
  - Required: every result matches a 129-bit reference model for sum, cout and ovf.
